// File: rtl/muldiv_pkg.sv
// Shared types and constants for the scalar multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/scalar_muldiv_unit_adder.sv
// N-bit ripple adder with carry in; C_flag is the carry out of the MSB.
// For subtraction the caller supplies the inverted operand and C_in=1, so
// C_flag=1 then means "no borrow".
module adder #(
  parameter int N = 24
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] r,
  output logic         c_flag
);

  // Full-width sum including the carry out.
  always_comb begin
    {c_flag, r} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
  end

endmodule

// File: rtl/scalar_muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per
// cycle, sharing a single N-bit adder between both operations.
module scalar_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result_lo,
  output logic [N-1:0] result_hi,
  output logic         div_zero,
  output logic         N_flag,
  output logic         Z_flag
);

  localparam int CNT_W = $clog2(N + 1);

  muldiv_state_t    state_r;
  logic [CNT_W-1:0] count_r;
  logic             op_r;
  // MUL: multiplicand; DIV: divisor
  logic [N-1:0]     opnd_r;
  // MUL: upper partial product; DIV: partial remainder
  logic [N-1:0]     acc_hi_r;
  // MUL: multiplier shifting out / product low; DIV: dividend shifting out / quotient
  logic [N-1:0]     acc_lo_r;

  logic [N-1:0]     add_a_s;
  logic [N-1:0]     add_b_s;
  logic             add_cin_s;
  logic [N-1:0]     add_r_s;
  logic             add_c_s;

  logic [N-1:0]     rem_sh_s;
  logic             rmsb_s;
  logic             q_bit_s;
  logic [N-1:0]     acc_hi_nxt_s;
  logic [N-1:0]     acc_lo_nxt_s;

  adder #(.N(N)) u_adder (
    .a      (add_a_s),
    .b      (add_b_s),
    .c_in   (add_cin_s),
    .r      (add_r_s),
    .c_flag (add_c_s)
  );

  // Adder operand mux: MUL adds multiplicand to acc_hi, DIV subtracts divisor from the shifted remainder.
  always_comb begin
    rem_sh_s = {acc_hi_r[N-2:0], acc_lo_r[N-1]};
    rmsb_s   = acc_hi_r[N-1];
    if (op_r == OP_DIV) begin
      add_a_s   = rem_sh_s;
      add_b_s   = ~opnd_r;
      add_cin_s = 1'b1;
    end else begin
      add_a_s   = acc_hi_r;
      add_b_s   = opnd_r;
      add_cin_s = 1'b0;
    end
  end

  // Next accumulator values for one iteration of the selected operation.
  always_comb begin
    // rmsb set means the shifted remainder already exceeds any N-bit divisor
    q_bit_s = rmsb_s | add_c_s;
    if (op_r == OP_DIV) begin
      acc_hi_nxt_s = q_bit_s ? add_r_s : rem_sh_s;
      acc_lo_nxt_s = {acc_lo_r[N-2:0], q_bit_s};
    end else if (acc_lo_r[0]) begin
      acc_hi_nxt_s = {add_c_s, add_r_s[N-1:1]};
      acc_lo_nxt_s = {add_r_s[0], acc_lo_r[N-1:1]};
    end else begin
      acc_hi_nxt_s = {1'b0, acc_hi_r[N-1:1]};
      acc_lo_nxt_s = {acc_hi_r[0], acc_lo_r[N-1:1]};
    end
  end

  // Control FSM, iteration state and registered results/flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      count_r   <= {CNT_W{1'b0}};
      op_r      <= OP_MUL;
      opnd_r    <= {N{1'b0}};
      acc_hi_r  <= {N{1'b0}};
      acc_lo_r  <= {N{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= {N{1'b0}};
      result_hi <= {N{1'b0}};
      div_zero  <= 1'b0;
      N_flag    <= 1'b0;
      Z_flag    <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r     <= op;
            count_r  <= {CNT_W{1'b0}};
            acc_hi_r <= {N{1'b0}};
            busy     <= 1'b1;
            if (op == OP_DIV) begin
              opnd_r   <= B;
              acc_lo_r <= A;
            end else begin
              opnd_r   <= A;
              acc_lo_r <= B;
            end
            if ((op == OP_DIV) && (B == {N{1'b0}})) begin
              // Divide by zero skips iteration entirely
              result_lo <= {N{1'b1}};
              result_hi <= A;
              div_zero  <= 1'b1;
              N_flag    <= 1'b1;
              Z_flag    <= 1'b0;
              done      <= 1'b1;
              state_r   <= DONE;
            end else begin
              state_r <= RUN;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          acc_hi_r <= acc_hi_nxt_s;
          acc_lo_r <= acc_lo_nxt_s;
          count_r  <= count_r + CNT_W'(1);
          if (count_r == CNT_W'(N - 1)) begin
            result_lo <= acc_lo_nxt_s;
            result_hi <= acc_hi_nxt_s;
            div_zero  <= 1'b0;
            N_flag    <= acc_lo_nxt_s[N-1];
            Z_flag    <= (acc_lo_nxt_s == {N{1'b0}});
            done      <= 1'b1;
            state_r   <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
